// File: rtl/adder_tree_arbiter.sv
// Round-robin arbiter sharing one combinational adder tree among NREQ
// requesters; the winning sum and requester ID are registered behind valid/ready.

module adder_tree #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N     = 4
) (
  input  logic [N*WIDTH-1:0] data_i,
  output logic [WIDTH-1:0]   sum_o
);

  always_comb begin
    sum_o = '0;
    for (int unsigned i = 0; i < N; i++) begin
      sum_o = sum_o + data_i[i*WIDTH +: WIDTH];
    end
  end

endmodule

module adder_tree_arbiter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N     = 4,
  parameter int unsigned NREQ  = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*N*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]           req_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_sum,
  output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] out_id
);

  localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_sum_q, out_sum_d;
  logic [IDW-1:0]     out_id_q, out_id_d;

  logic [NREQ-1:0]    gnt;
  logic               gnt_found;
  logic [IDW-1:0]     gnt_id;
  logic [IDW-1:0]     nxt_ptr;
  logic [N*WIDTH-1:0] gnt_data;
  logic [WIDTH-1:0]   gnt_sum;
  logic               accept;
  logic               transfer;

  // Search offsets k = 0..NREQ-1 from rr_ptr; the first valid requester wins.
  always_comb begin
    gnt       = '0;
    gnt_found = 1'b0;
    gnt_id    = '0;
    gnt_data  = '0;
    nxt_ptr   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      for (int unsigned r = 0; r < NREQ; r++) begin
        if (!gnt_found && req_valid[r] && (r == (32'(rr_ptr_q) + k) % NREQ)) begin
          gnt_found = 1'b1;
          gnt[r]    = 1'b1;
          gnt_id    = IDW'(r);
          gnt_data  = req_data[r*N*WIDTH +: N*WIDTH];
          nxt_ptr   = IDW'((r + 1) % NREQ);
        end
      end
    end
  end

  adder_tree #(
    .WIDTH (WIDTH),
    .N     (N)
  ) u_adder_tree (
    .data_i (gnt_data),
    .sum_o  (gnt_sum)
  );

  assign accept    = !out_valid_q || out_ready;
  assign req_ready = (rst_n && accept) ? gnt : '0;
  assign transfer  = |req_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_id_d    = out_id_q;
    rr_ptr_d    = rr_ptr_q;
    if (accept) begin
      out_valid_d = transfer;
    end
    if (transfer) begin
      out_sum_d = gnt_sum;
      out_id_d  = gnt_id;
      rr_ptr_d  = nxt_ptr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_id_q    <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_id_q    <= out_id_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_id    = out_id_q;

endmodule
